apb2axi_dir_table: RTL and testbench

- Parametrised outstanding-transaction directory for the APB2AXI converter.
- Holds up to TAG_NUM committed requests, each stored as a directory entry with a lifecycle state.
- The gateway allocates entries, the AXI builder issues them in commit order, and the response path completes them. The APB readback path retires them.
- Generalises the fixed 16-entry directory type:
  - configurable depth and widths;
  - oldest-first issue queue;
  - illegal-event flagging;
  - optional watchdog.

---
 rtl/apb2axi_dir_table.sv | 239 +++++++++++++++++++++++
 tb/tb_apb2axi_dir_table.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_dir_table.sv
// apb2axi_dir_table
//   Outstanding-transaction directory for the APB2AXI converter. Holds up to
//   TAG_NUM committed requests. Each entry has a lifecycle state:
//     EMPTY -> PENDING (alloc) -> ISSUED (issue handshake)
//           -> DONE / ERROR (completion) -> EMPTY (free)
//   STAGED exists in the encoding but is never entered.
//   Requests are issued oldest first through a circular FIFO of tags.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   alloc_*             gateway commit; alloc_tag is the lowest EMPTY entry
//   issue_*             head-of-queue entry offered to the AXI builder
//   cpl_*               completion from the response path (resp[1] = error)
//   free_*              retire from the APB readback path
//   query_tag/state     combinational state lookup; doubles as the debug view
//   used_cnt            number of non-EMPTY entries
//   pending_cnt         number of PENDING entries (= queue occupancy)
//   illegal_evt         one-cycle pulse after a rejected cpl and/or free
//   timeout_evt         one-cycle pulse after a watchdog expiry
//
// Handshakes
//   Valid/ready semantics throughout. A transfer happens in a cycle where both
//   valid and ready are high at the rising clock edge. alloc_ready and
//   issue_valid come only from registered state, so they never depend on the
//   partner's valid/ready in the same cycle. While issue_valid is high and
//   issue_ready is low, the issue_* outputs hold stable.
//
// Configuration
//   APB2AXI_DIR_TIMEOUT_EN : when defined, each ISSUED entry ages. When its
//   age reaches TIMEOUT_CYC-1 it becomes ERROR and timeout_evt pulses. A
//   completion arriving in that same cycle wins. When undefined, no age
//   counters are built and timeout_evt is tied to 0.
module apb2axi_dir_table #(
  parameter int TAG_NUM     = 16,
  parameter int TAG_W       = $clog2(TAG_NUM),
  parameter int ADDR_W      = 64,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_is_write,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [LEN_W-1:0]  alloc_len,
  input  logic [2:0]        alloc_size,
  input  logic [1:0]        alloc_burst,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic              issue_is_write,
  output logic [ADDR_W-1:0] issue_addr,
  output logic [LEN_W-1:0]  issue_len,
  output logic [2:0]        issue_size,
  output logic [1:0]        issue_burst,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cpl_valid,
  input  logic [TAG_W-1:0]  cpl_tag,
  input  logic [1:0]        cpl_resp,
  input  logic              free_valid,
  input  logic [TAG_W-1:0]  free_tag,
  input  logic [TAG_W-1:0]  query_tag,
  output logic [2:0]        query_state,
  output logic [TAG_W:0]    used_cnt,
  output logic [TAG_W:0]    pending_cnt,
  output logic              illegal_evt,
  output logic              timeout_evt
);

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'd0,
    ST_PENDING = 3'd1,
    ST_STAGED  = 3'd2,
    ST_ISSUED  = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } dir_state_e;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } entry_t;

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(TAG_NUM);

  dir_state_e       state_q [TAG_NUM];
  dir_state_e       state_d [TAG_NUM];
  entry_t           entry_q [TAG_NUM];
  entry_t           entry_d [TAG_NUM];
  logic [TAG_W-1:0] fifo_q  [TAG_NUM];
  logic [TAG_W-1:0] fifo_d  [TAG_NUM];
  logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_W:0]   used_cnt_q, used_cnt_d;
  logic [TAG_W:0]   pending_cnt_q, pending_cnt_d;
  logic             illegal_q, illegal_d;

  logic [TAG_W-1:0] free_idx;
  logic [TAG_W-1:0] head_tag;
  logic             push, pop, cpl_ok, free_ok;
  logic             unused_resp;

  // Only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp = cpl_resp[0];

`ifdef APB2AXI_DIR_TIMEOUT_EN
  localparam int AGE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYC - 1);
  logic [AGE_W-1:0] age_q [TAG_NUM];
  logic [AGE_W-1:0] age_d [TAG_NUM];
  logic             timeout_q, timeout_d;
  assign timeout_evt = timeout_q;
`else
  assign timeout_evt = 1'b0;
`endif

  // Lowest-index EMPTY entry. Scanning downward lets the last hit win.
  always_comb begin
    free_idx = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (state_q[i] == ST_EMPTY) free_idx = TAG_W'(i);
    end
  end

  assign head_tag    = fifo_q[rd_ptr_q];
  assign alloc_ready = (used_cnt_q != FULL_CNT);
  assign alloc_tag   = free_idx;
  assign issue_valid = (pending_cnt_q != '0);

  assign push    = alloc_valid && alloc_ready;
  assign pop     = issue_valid && issue_ready;
  assign cpl_ok  = cpl_valid && (state_q[cpl_tag] == ST_ISSUED);
  assign free_ok = free_valid &&
                   ((state_q[free_tag] == ST_DONE) || (state_q[free_tag] == ST_ERROR));

  assign issue_is_write = entry_q[head_tag].is_write;
  assign issue_addr     = entry_q[head_tag].addr;
  assign issue_len      = entry_q[head_tag].len;
  assign issue_size     = entry_q[head_tag].size;
  assign issue_burst    = entry_q[head_tag].burst;
  assign issue_tag      = head_tag;

  assign query_state = state_q[query_tag];
  assign used_cnt    = used_cnt_q;
  assign pending_cnt = pending_cnt_q;
  assign illegal_evt = illegal_q;

  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    used_cnt_d    = used_cnt_q;
    pending_cnt_d = pending_cnt_q;
    illegal_d     = (cpl_valid && !cpl_ok) || (free_valid && !free_ok);
`ifdef APB2AXI_DIR_TIMEOUT_EN
    age_d     = age_q;
    timeout_d = 1'b0;
    // Watchdog runs first so that a same-cycle completion overrides it below.
    for (int i = 0; i < TAG_NUM; i++) begin
      if (state_q[i] == ST_ISSUED) begin
        if ((age_q[i] == AGE_MAX) && !(cpl_ok && (cpl_tag == TAG_W'(i)))) begin
          state_d[i] = ST_ERROR;
          timeout_d  = 1'b1;
        end else begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
`endif
    // alloc, issue, cpl and free always hit distinct entries because each
    // one requires a different current state.
    if (push) begin
      state_d[free_idx] = ST_PENDING;
      entry_d[free_idx] = '{is_write: alloc_is_write, addr: alloc_addr,
                            len: alloc_len, size: alloc_size, burst: alloc_burst};
      fifo_d[wr_ptr_q]  = free_idx;
      wr_ptr_d          = wr_ptr_q + TAG_W'(1);
`ifdef APB2AXI_DIR_TIMEOUT_EN
      age_d[free_idx]   = '0;
`endif
    end
    if (pop) begin
      state_d[head_tag] = ST_ISSUED;
      rd_ptr_d          = rd_ptr_q + TAG_W'(1);
`ifdef APB2AXI_DIR_TIMEOUT_EN
      age_d[head_tag]   = '0;
`endif
    end
    if (cpl_ok)  state_d[cpl_tag]  = cpl_resp[1] ? ST_ERROR : ST_DONE;
    if (free_ok) state_d[free_tag] = ST_EMPTY;

    if (push && !free_ok)      used_cnt_d = used_cnt_q + (TAG_W+1)'(1);
    else if (!push && free_ok) used_cnt_d = used_cnt_q - (TAG_W+1)'(1);

    if (push && !pop)      pending_cnt_d = pending_cnt_q + (TAG_W+1)'(1);
    else if (!push && pop) pending_cnt_d = pending_cnt_q - (TAG_W+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        state_q[i] <= ST_EMPTY;
        entry_q[i] <= '0;
        fifo_q[i]  <= '0;
`ifdef APB2AXI_DIR_TIMEOUT_EN
        age_q[i]   <= '0;
`endif
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      used_cnt_q    <= '0;
      pending_cnt_q <= '0;
      illegal_q     <= 1'b0;
`ifdef APB2AXI_DIR_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      used_cnt_q    <= used_cnt_d;
      pending_cnt_q <= pending_cnt_d;
      illegal_q     <= illegal_d;
`ifdef APB2AXI_DIR_TIMEOUT_EN
      age_q         <= age_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb2axi_dir_table.sv
module tb_apb2axi_dir_table;
  localparam int TAG_NUM = 16;
  localparam int TAG_W   = 4;
  localparam int ADDR_W  = 64;
  localparam int LEN_W   = 8;

  localparam logic [2:0] S_EMPTY   = 3'd0;
  localparam logic [2:0] S_PENDING = 3'd1;
  localparam logic [2:0] S_ISSUED  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              alloc_valid, alloc_ready, alloc_is_write;
  logic [ADDR_W-1:0] alloc_addr;
  logic [LEN_W-1:0]  alloc_len;
  logic [2:0]        alloc_size;
  logic [1:0]        alloc_burst;
  logic [TAG_W-1:0]  alloc_tag;
  logic              issue_valid, issue_ready, issue_is_write;
  logic [ADDR_W-1:0] issue_addr;
  logic [LEN_W-1:0]  issue_len;
  logic [2:0]        issue_size;
  logic [1:0]        issue_burst;
  logic [TAG_W-1:0]  issue_tag;
  logic              cpl_valid;
  logic [TAG_W-1:0]  cpl_tag;
  logic [1:0]        cpl_resp;
  logic              free_valid;
  logic [TAG_W-1:0]  free_tag;
  logic [TAG_W-1:0]  query_tag;
  logic [2:0]        query_state;
  logic [TAG_W:0]    used_cnt, pending_cnt;
  logic              illegal_evt, timeout_evt;

  apb2axi_dir_table #(
    .TAG_NUM(TAG_NUM), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_is_write(alloc_is_write),
    .alloc_addr(alloc_addr), .alloc_len(alloc_len), .alloc_size(alloc_size),
    .alloc_burst(alloc_burst), .alloc_tag(alloc_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_write(issue_is_write),
    .issue_addr(issue_addr), .issue_len(issue_len), .issue_size(issue_size),
    .issue_burst(issue_burst), .issue_tag(issue_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_resp(cpl_resp),
    .free_valid(free_valid), .free_tag(free_tag),
    .query_tag(query_tag), .query_state(query_state),
    .used_cnt(used_cnt), .pending_cnt(pending_cnt),
    .illegal_evt(illegal_evt), .timeout_evt(timeout_evt)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- reference model ----------------
  logic [2:0]        m_state [TAG_NUM];
  logic              m_wr    [TAG_NUM];
  logic [ADDR_W-1:0] m_addr  [TAG_NUM];
  logic [LEN_W-1:0]  m_len   [TAG_NUM];
  logic [2:0]        m_size  [TAG_NUM];
  logic [1:0]        m_burst [TAG_NUM];
  logic [TAG_W-1:0]  m_q[$];
  logic              m_illegal;

  function automatic void model_reset();
    for (int i = 0; i < TAG_NUM; i++) m_state[i] = S_EMPTY;
    m_q.delete();
    m_illegal = 1'b0;
  endfunction

  function automatic int m_used();
    int n = 0;
    for (int i = 0; i < TAG_NUM; i++) if (m_state[i] != S_EMPTY) n++;
    return n;
  endfunction

  function automatic int m_lowest_empty();
    for (int i = 0; i < TAG_NUM; i++) if (m_state[i] == S_EMPTY) return i;
    return -1;
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  ft;
    bit  push, pop, cok, fok;
    logic [TAG_W-1:0] h;
    ft   = m_lowest_empty();
    push = alloc_valid && (ft >= 0);
    pop  = issue_ready && (m_q.size() != 0);
    cok  = cpl_valid && (m_state[cpl_tag] == S_ISSUED);
    fok  = free_valid && ((m_state[free_tag] == S_DONE) || (m_state[free_tag] == S_ERROR));
    m_illegal = (cpl_valid && !cok) || (free_valid && !fok);
    if (pop) begin
      h = m_q.pop_front();
      m_state[h] = S_ISSUED;
    end
    if (push) begin
      m_state[ft] = S_PENDING;
      m_wr[ft] = alloc_is_write; m_addr[ft] = alloc_addr; m_len[ft] = alloc_len;
      m_size[ft] = alloc_size; m_burst[ft] = alloc_burst;
      m_q.push_back(TAG_W'(ft));
    end
    if (cok) m_state[cpl_tag] = cpl_resp[1] ? S_ERROR : S_DONE;
    if (fok) m_state[free_tag] = S_EMPTY;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    alloc_valid = 1'b0; alloc_is_write = 1'b0; alloc_addr = '0; alloc_len = '0;
    alloc_size = '0; alloc_burst = '0; issue_ready = 1'b0;
    cpl_valid = 1'b0; cpl_tag = '0; cpl_resp = '0;
    free_valid = 1'b0; free_tag = '0; query_tag = '0;
  endtask

  task automatic rand_alloc_fields();
    alloc_is_write = 1'($urandom_range(0, 1));
    alloc_addr     = {$urandom, $urandom};
    alloc_len      = LEN_W'($urandom_range(0, 255));
    alloc_size     = 3'($urandom_range(0, 7));
    alloc_burst    = 2'($urandom_range(0, 2));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
      err_cnt++; $display("FAIL reset_alloc: ready=%b tag=%0d want ready=1 tag=0", alloc_ready, alloc_tag);
    end
    vec_cnt++;
    if (issue_valid !== 1'b0 || used_cnt !== 5'd0 || pending_cnt !== 5'd0) begin
      err_cnt++; $display("FAIL reset_cnt: iv=%b used=%0d pend=%0d want 0/0/0", issue_valid, used_cnt, pending_cnt);
    end
    vec_cnt++;
    if (illegal_evt !== 1'b0 || timeout_evt !== 1'b0) begin
      err_cnt++; $display("FAIL reset_evt: ill=%b to=%b want 0/0", illegal_evt, timeout_evt);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < TAG_NUM; i++) begin
      alloc_valid = 1'b1;
      rand_alloc_fields();
      #1;
      vec_cnt++;
      if (alloc_ready !== 1'b1 || alloc_tag !== TAG_W'(i)) begin
        err_cnt++; $display("FAIL fill_tag: ready=%b tag=%0d want ready=1 tag=%0d", alloc_ready, alloc_tag, i);
      end
      if (i == 0) begin
        vec_cnt++;
        if (issue_valid !== 1'b0) begin
          err_cnt++; $display("FAIL fill_latency: issue_valid=%b want 0", issue_valid);
        end
      end
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    vec_cnt++;
    if (alloc_ready !== 1'b0 || used_cnt !== 5'd16 || pending_cnt !== 5'd16) begin
      err_cnt++; $display("FAIL fill_full: ready=%b used=%0d pend=%0d want 0/16/16", alloc_ready, used_cnt, pending_cnt);
    end
    vec_cnt++;
    if (issue_valid !== 1'b1 || issue_tag !== 4'd0 || issue_addr !== m_addr[0]) begin
      err_cnt++; $display("FAIL fill_head: iv=%b tag=%0d addr=%h want 1/0/%h", issue_valid, issue_tag, issue_addr, m_addr[0]);
    end
  endtask

  task automatic test_issue_order();
    logic [ADDR_W-1:0] ea [3];
    logic [LEN_W-1:0]  el [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      rand_alloc_fields();
      ea[i] = alloc_addr; el[i] = alloc_len;
      tick();
    end
    alloc_valid = 1'b0;
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++;
      if (issue_valid !== 1'b1 || issue_tag !== TAG_W'(i) || issue_addr !== ea[i] || issue_len !== el[i]) begin
        err_cnt++; $display("FAIL issue_order: iv=%b tag=%0d addr=%h len=%0d want 1/%0d/%h/%0d",
                            issue_valid, issue_tag, issue_addr, issue_len, i, ea[i], el[i]);
      end
      tick();
    end
    issue_ready = 1'b0;
    query_tag = 4'd1;
    #1;
    vec_cnt++;
    if (query_state !== S_ISSUED || issue_valid !== 1'b0 || pending_cnt !== 5'd0) begin
      err_cnt++; $display("FAIL issue_state: q=%0d iv=%b pend=%0d want %0d/0/0", query_state, issue_valid, pending_cnt, S_ISSUED);
    end
  endtask

  task automatic test_cpl_error();
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alloc_valid = (i < 4);
      rand_alloc_fields();
      tick();
    end
    drive_idle();
    cpl_valid = 1'b1; cpl_tag = 4'd3; cpl_resp = 2'b10;
    tick();
    cpl_tag = 4'd0; cpl_resp = 2'b01;
    tick();
    drive_idle();
    query_tag = 4'd3;
    #1;
    vec_cnt++;
    if (query_state !== S_ERROR || illegal_evt !== 1'b0) begin
      err_cnt++; $display("FAIL cpl_error: q=%0d ill=%b want %0d/0", query_state, illegal_evt, S_ERROR);
    end
    query_tag = 4'd0;
    #1;
    vec_cnt++;
    if (query_state !== S_DONE) begin
      err_cnt++; $display("FAIL cpl_done: q=%0d want %0d", query_state, S_DONE);
    end
    free_valid = 1'b1; free_tag = 4'd3;
    tick();
    drive_idle();
    query_tag = 4'd3;
    #1;
    vec_cnt++;
    if (query_state !== S_EMPTY || alloc_tag !== 4'd3 || used_cnt !== 5'd3) begin
      err_cnt++; $display("FAIL free_realloc: q=%0d tag=%0d used=%0d want 0/3/3", query_state, alloc_tag, used_cnt);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alloc_valid = (i < 7);
      rand_alloc_fields();
      tick();
    end
    drive_idle();
    cpl_valid = 1'b1; cpl_tag = 4'd5; cpl_resp = 2'b00;
    tick();
    drive_idle();
    free_valid = 1'b1; free_tag = 4'd5;
    tick();
    drive_idle();
    alloc_valid = 1'b1; rand_alloc_fields();
    tick();
    drive_idle();
    cpl_valid = 1'b1; cpl_tag = 4'd5;
    free_valid = 1'b1; free_tag = 4'd6;
    #1;
    vec_cnt++;
    if (illegal_evt !== 1'b0) begin
      err_cnt++; $display("FAIL illegal_early: ill=%b want 0", illegal_evt);
    end
    tick();
    drive_idle();
    query_tag = 4'd5;
    #1;
    vec_cnt++;
    if (illegal_evt !== 1'b1 || query_state !== S_PENDING) begin
      err_cnt++; $display("FAIL illegal_pulse: ill=%b q5=%0d want 1/%0d", illegal_evt, query_state, S_PENDING);
    end
    tick();
    query_tag = 4'd6;
    #1;
    vec_cnt++;
    if (illegal_evt !== 1'b0 || query_state !== S_ISSUED) begin
      err_cnt++; $display("FAIL illegal_clear: ill=%b q6=%0d want 0/%0d", illegal_evt, query_state, S_ISSUED);
    end
  endtask

  task automatic test_full_free();
    do_reset();
    for (int i = 0; i < TAG_NUM; i++) begin
      alloc_valid = 1'b1; rand_alloc_fields();
      tick();
    end
    drive_idle();
    issue_ready = 1'b1;
    repeat (8) tick();
    drive_idle();
    cpl_valid = 1'b1; cpl_tag = 4'd7; cpl_resp = 2'b00;
    tick();
    drive_idle();
    free_valid = 1'b1; free_tag = 4'd7;
    alloc_valid = 1'b1; rand_alloc_fields();
    #1;
    vec_cnt++;
    if (alloc_ready !== 1'b0) begin
      err_cnt++; $display("FAIL full_free_same: ready=%b want 0", alloc_ready);
    end
    tick();
    free_valid = 1'b0;
    #1;
    vec_cnt++;
    if (alloc_ready !== 1'b1 || alloc_tag !== 4'd7 || used_cnt !== 5'd15) begin
      err_cnt++; $display("FAIL full_free_next: ready=%b tag=%0d used=%0d want 1/7/15", alloc_ready, alloc_tag, used_cnt);
    end
    tick();
    alloc_valid = 1'b0;
    query_tag = 4'd7;
    #1;
    vec_cnt++;
    if (used_cnt !== 5'd16 || query_state !== S_PENDING || alloc_ready !== 1'b0) begin
      err_cnt++; $display("FAIL full_realloc: used=%0d q7=%0d ready=%b want 16/%0d/0", used_cnt, query_state, alloc_ready, S_PENDING);
    end
  endtask

  task automatic test_random();
    int cands[$];
    int exp_tag;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      drive_idle();
      alloc_valid = ($urandom_range(0, 99) < 55);
      rand_alloc_fields();
      issue_ready = 1'($urandom_range(0, 1));
      cands.delete();
      for (int i = 0; i < TAG_NUM; i++) if (m_state[i] == S_ISSUED) cands.push_back(i);
      if (cands.size() != 0 && $urandom_range(0, 99) < 45) begin
        cpl_valid = 1'b1; cpl_tag = TAG_W'(cands[$urandom_range(0, cands.size() - 1)]);
      end else if ($urandom_range(0, 99) < 6) begin
        cpl_valid = 1'b1; cpl_tag = TAG_W'($urandom_range(0, TAG_NUM - 1));
      end
      cpl_resp = 2'($urandom_range(0, 3));
      cands.delete();
      for (int i = 0; i < TAG_NUM; i++)
        if (m_state[i] == S_DONE || m_state[i] == S_ERROR) cands.push_back(i);
      if (cands.size() != 0 && $urandom_range(0, 99) < 40) begin
        free_valid = 1'b1; free_tag = TAG_W'(cands[$urandom_range(0, cands.size() - 1)]);
      end else if ($urandom_range(0, 99) < 6) begin
        free_valid = 1'b1; free_tag = TAG_W'($urandom_range(0, TAG_NUM - 1));
      end
      query_tag = TAG_W'($urandom_range(0, TAG_NUM - 1));
      #1;
      exp_tag = m_lowest_empty();
      vec_cnt++;
      if (alloc_ready !== (exp_tag >= 0) || (exp_tag >= 0 && alloc_tag !== TAG_W'(exp_tag))) begin
        err_cnt++; $display("FAIL rnd_alloc: cyc=%0d ready=%b tag=%0d want tag=%0d", cyc, alloc_ready, alloc_tag, exp_tag);
      end
      vec_cnt++;
      if (issue_valid !== (m_q.size() != 0)) begin
        err_cnt++; $display("FAIL rnd_issue_valid: cyc=%0d got=%b want=%b", cyc, issue_valid, m_q.size() != 0);
      end else if (m_q.size() != 0) begin
        vec_cnt++;
        if (issue_tag !== m_q[0] || issue_addr !== m_addr[m_q[0]] || issue_len !== m_len[m_q[0]] ||
            issue_is_write !== m_wr[m_q[0]] || issue_size !== m_size[m_q[0]] || issue_burst !== m_burst[m_q[0]]) begin
          err_cnt++; $display("FAIL rnd_issue_fields: cyc=%0d tag=%0d addr=%h want tag=%0d addr=%h",
                              cyc, issue_tag, issue_addr, m_q[0], m_addr[m_q[0]]);
        end
      end
      vec_cnt++;
      if (used_cnt !== (TAG_W+1)'(m_used()) || pending_cnt !== (TAG_W+1)'(m_q.size())) begin
        err_cnt++; $display("FAIL rnd_counts: cyc=%0d used=%0d pend=%0d want %0d/%0d",
                            cyc, used_cnt, pending_cnt, m_used(), m_q.size());
      end
      vec_cnt++;
      if (illegal_evt !== m_illegal || timeout_evt !== 1'b0) begin
        err_cnt++; $display("FAIL rnd_events: cyc=%0d ill=%b to=%b want %b/0", cyc, illegal_evt, timeout_evt, m_illegal);
      end
      vec_cnt++;
      if (query_state !== m_state[query_tag]) begin
        err_cnt++; $display("FAIL rnd_query: cyc=%0d tag=%0d got=%0d want=%0d", cyc, query_tag, query_state, m_state[query_tag]);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    alloc_valid = 1'b1; rand_alloc_fields();
    tick();
    drive_idle();
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (used_cnt !== 5'd0 || pending_cnt !== 5'd0 || issue_valid !== 1'b0 ||
        alloc_tag !== 4'd0 || alloc_ready !== 1'b1 || illegal_evt !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid: used=%0d pend=%0d iv=%b tag=%0d ready=%b ill=%b want 0/0/0/0/1/0",
                          used_cnt, pending_cnt, issue_valid, alloc_tag, alloc_ready, illegal_evt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_fill();
    test_issue_order();
    test_cpl_error();
    test_illegal();
    test_full_free();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
